// File: rtl/alu_seq_exec.sv
// ---------------------------------------------------------------------------
// alu_seq_exec
//
// Execution-side consumer of the 4-bit ALUControl code. The block latches an
// operation and its two operands over a valid/ready handshake and returns a
// registered result plus flags over a second valid/ready handshake.
//
// Single-cycle ops (add/sub/logic/compare) land in DONE one cycle after the
// accept. Shifts run iteratively at one bit per cycle, so they take shamt+1
// cycles from accept to out_valid. A shift amount of 0 behaves like a
// single-cycle op and returns a.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   flush       synchronous abort; drops any in-flight op, keeps result/flags
//   in_valid    op/operands valid
//   in_ready    block can accept an op (high only in IDLE)
//   ALUControl  operation code
//   a           operand A (shift source)
//   b           operand B (shift amount = b[SHAMT_W-1:0])
//   out_valid   result valid (high only in DONE)
//   out_ready   consumer accepts result
//   result      registered result
//   zero        result == 0
//   negative    result[WIDTH-1]
//   carry       add: carry-out; sub: no-borrow (a >= b unsigned); else 0
//   overflow    signed overflow for add/sub; else 0
// ---------------------------------------------------------------------------
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ALUControl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               negative,
    output logic               carry,
    output logic               overflow
);

    // Operation codes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Latched operation and iterative shift state
    logic [3:0]         code_reg;
    logic [WIDTH-1:0]   work_reg;
    logic [SHAMT_W-1:0] cnt_reg;

    // Registered result and flags
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic               negative_reg;
    logic               carry_reg;
    logic               overflow_reg;

    // Input-side decode
    logic [SHAMT_W-1:0] shamt_in;
    logic               in_is_shift;
    logic               in_needs_shift;
    logic               last_shift;

    assign shamt_in       = b[SHAMT_W-1:0];
    assign in_is_shift    = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                            (ALUControl == OP_SRA);
    // Only a nonzero shift amount needs the SHIFT state
    assign in_needs_shift = in_is_shift && (shamt_in != '0);
    // The step taken while the counter reads 1 is the final one
    assign last_shift     = (cnt_reg == SHAMT_W'(1));

    // -----------------------------------------------------------------------
    // Single-cycle ALU, evaluated on the live inputs during the accept cycle.
    // Shift codes return a unchanged, which is exactly the shamt=0 result.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;

    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        // a + ~b + 1: the top bit is the no-borrow indication (a >= b unsigned)
        diff_ext  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == ~b[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL,
            OP_SRL,
            OP_SRA:  alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // One-bit shift step of the working register, built bit by bit.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] left_step;
    logic [WIDTH-1:0] right_step;
    logic [WIDTH-1:0] step_val;
    logic             right_fill;

    // sra replicates the sign bit, srl fills with zero
    assign right_fill = (code_reg == OP_SRA) ? work_reg[WIDTH-1] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign left_step[gi] = 1'b0;
            end else begin : g_lo
                assign left_step[gi] = work_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign right_step[gi] = right_fill;
            end else begin : g_hi
                assign right_step[gi] = work_reg[gi+1];
            end
        end
    endgenerate

    assign step_val = (code_reg == OP_SLL) ? left_step : right_step;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. flush wins over everything, including accept.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_next = in_needs_shift ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    if (last_shift) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. No accept in DONE, so throughput is one op per 2 cycles.
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers. A flush freezes everything here: the result and
    // flags keep their last values and stale shift state is simply reloaded
    // on the next accept.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_reg     <= '0;
            work_reg     <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b0;
            negative_reg <= 1'b0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (!flush) begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        code_reg <= ALUControl;
                        work_reg <= a;
                        cnt_reg  <= shamt_in;
                        if (!in_needs_shift) begin
                            result_reg   <= alu_res;
                            zero_reg     <= (alu_res == '0);
                            negative_reg <= alu_res[WIDTH-1];
                            carry_reg    <= alu_carry;
                            overflow_reg <= alu_ovf;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_reg <= step_val;
                    cnt_reg  <= cnt_reg - SHAMT_W'(1);
                    if (last_shift) begin
                        result_reg   <= step_val;
                        zero_reg     <= (step_val == '0);
                        negative_reg <= step_val[WIDTH-1];
                        carry_reg    <= 1'b0;
                        overflow_reg <= 1'b0;
                    end
                end
                default: begin
                    // DONE: hold result and flags for the consumer
                end
            endcase
        end
    end

    assign result   = result_reg;
    assign zero     = zero_reg;
    assign negative = negative_reg;
    assign carry    = carry_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors: flags are {zero, negative, carry, overflow}
    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        logic [7:0]  lat;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC] = '{
        '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 8'd1},  // add overflow
        '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1010, 8'd1},  // sub equal
        '{4'b1000, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b0100, 8'd5},  // sra 4
        '{4'b0111, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 4'b0000, 8'd5},  // srl 4
        '{4'b0100, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b0100, 8'd32}, // sll 31
        '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, 8'd1},  // slt
        '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1000, 8'd1},  // sltu
        '{4'b1111, 32'h1234_5678, 32'h0000_0003, 32'h0000_0000, 4'b1000, 8'd1},  // unused code
        '{4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 8'd1},  // and
        '{4'b0110, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 4'b0000, 8'd1},  // xor
        '{4'b0100, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 4'b0000, 8'd1},  // sll shamt 0
        '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 8'd1},  // add carry
        '{4'b0001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0100, 8'd1},  // sub borrow
        '{4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 8'd1},  // sub overflow
        '{4'b1000, 32'h4000_0000, 32'h0000_0021, 32'h2000_0000, 4'b0000, 8'd2}   // sra 1
    };

    // Drive one op at a negedge, then count rising edges (accept edge is the
    // first) until out_valid. Operands are scrambled after the accept edge.
    task automatic run_op(input logic [3:0] code, input logic [31:0] opa,
                          input logic [31:0] opb, output int lat);
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = code;
        a          = opa;
        b          = opb;
        lat        = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid   = 1'b0;
            ALUControl = 4'b0001;
            a          = 32'hDEAD_BEEF;
            b          = 32'h0000_0013;
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    // Complete the handshake for the result currently presented
    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_checks++;
        if ({result, zero, negative, carry, overflow} !== 36'h0) begin
            n_fail++; $display("FAIL reset_result_flags got %h %b%b%b%b want 0",
                               result, zero, negative, carry, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: out_valid=%b in_ready=%b result=%h", out_valid, in_ready, result);
    endtask

    task automatic test_ops();
        int lat;
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, lat);
            $display("op code=%b a=%h b=%h -> result=%h flags=%b%b%b%b latency=%0d",
                     vecs[i].code, vecs[i].a, vecs[i].b, result,
                     zero, negative, carry, overflow, lat);
            n_checks++;
            if (lat !== int'(vecs[i].lat)) begin
                n_fail++; $display("FAIL op%0d_latency got %0d want %0d", i, lat, vecs[i].lat);
            end
            n_checks++;
            if (result !== vecs[i].res) begin
                n_fail++; $display("FAIL op%0d_result got %h want %h", i, result, vecs[i].res);
            end
            n_checks++;
            if ({zero, negative, carry, overflow} !== vecs[i].flags) begin
                n_fail++; $display("FAIL op%0d_flags got %b%b%b%b want %b", i,
                                   zero, negative, carry, overflow, vecs[i].flags);
            end
            release_result();
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++; $display("FAIL op%0d_release got valid/ready %b%b want 01",
                                   i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int seen;
        // Leave a nonzero result behind so the clear is visible
        run_op(4'b0000, 32'd1, 32'd1, lat);
        release_result();
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = 4'b0100;
        a          = 32'h0000_000F;
        b          = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midshift_busy got in_ready %b want 0", in_ready);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL midshift_reset_hs got valid/ready %b%b want 01",
                               out_valid, in_ready);
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL midshift_reset_result got %h want 0", result);
        end
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL midshift_no_result got %0d valid cycles want 0", seen);
        end
        $display("reset mid-shift: result=%h in_ready=%b", result, in_ready);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] held;
        run_op(4'b0000, 32'd100, 32'd23, lat);
        held = result;
        n_checks++;
        if (held !== 32'd123) begin
            n_fail++; $display("FAIL bp_first_result got %h want %h", held, 32'd123);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, in_ready, result} !== {2'b10, held}) begin
                n_fail++; $display("FAIL bp_hold%0d got valid/ready %b%b result %h want 10 %h",
                                   i, out_valid, in_ready, result, held);
            end
        end
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        ALUControl = 4'b0000;
        a          = 32'd10;
        b          = 32'd20;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_release got valid/ready %b%b want 01", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, result} !== {1'b1, 32'd30}) begin
            n_fail++; $display("FAIL bp_next_op got valid %b result %h want 1 %h",
                               out_valid, result, 32'd30);
        end
        $display("back-to-back: held=%h next=%h", held, result);
        release_result();
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        logic [31:0] prev;
        prev = result;
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = 4'b0100;
        a          = 32'd1;
        b          = 32'd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;          // second SHIFT cycle
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL flush_idle got valid/ready %b%b want 01", out_valid, in_ready);
        end
        n_checks++;
        if (result !== prev) begin
            n_fail++; $display("FAIL flush_result_kept got %h want %h", result, prev);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen);
        end
        run_op(4'b0000, 32'd2, 32'd3, lat);
        n_checks++;
        if ({lat, result} !== {32'd1, 32'd5}) begin
            n_fail++; $display("FAIL flush_after_add got latency %0d result %h want 1 %h",
                               lat, result, 32'd5);
        end
        $display("flush: after-add result=%h latency=%0d", result, lat);
        release_result();
        // flush and in_valid together in IDLE: nothing accepted
        @(negedge clk);
        in_valid   = 1'b1;
        flush      = 1'b1;
        ALUControl = 4'b0000;
        a          = 32'd7;
        b          = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, in_ready, result} !== {2'b01, 32'd5}) begin
            n_fail++; $display("FAIL flush_priority got valid/ready %b%b result %h want 01 %h",
                               out_valid, in_ready, result, 32'd5);
        end
        $display("flush priority: in_ready=%b result=%h", in_ready, result);
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        ALUControl = 4'b0000;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;
        test_reset();
        test_ops();
        test_reset_mid_shift();
        test_back_to_back();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Execution-side consumer of the 4-bit ALUControl code produced by the ALU decoder. It latches an operation and two operands over a valid/ready handshake and computes the result. Single-cycle ops complete in one cycle; shifts run iteratively at 1 bit/cycle. It returns a registered result plus flags over a second valid/ready handshake, and sits between the register-read stage and writeback in the multi-cycle core.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort; drops any in-flight op
in_valid  input  1  op/operands valid
in_ready  output  1  block can accept an op
ALUControl  input  4  operation code
a  input  WIDTH  operand A (shift source)
b  input  WIDTH  operand B (shift amount = b[SHAMT_W-1:0])
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  result == 0
negative  output  1  result[WIDTH-1]
carry  output  1  add: carry-out; sub: 1 when a >= b unsigned (no borrow); else 0
overflow  output  1  signed overflow for add/sub; else 0

Behaviour:
- Code map: 0000 add; 0001 sub; 0010 and; 0011 or; 0100 sll; 0101 slt (signed, result 1/0); 0110 xor; 0111 srl; 1000 sra; 1001 sltu (unsigned); all other codes produce result 0 and flags computed from that 0 (zero=1).
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; zero=0; negative=0; carry=0; overflow=0.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). Accept on the cycle where in_valid & in_ready are both high. Capture code, a and shamt.
- IDLE, non-shift accepted: next cycle state=DONE, out_valid=1, result/flags registered. Latency 1.
- IDLE, shift accepted with shamt=0: DONE next cycle with result=a. Latency 1.
- IDLE, shift accepted with shamt>0: go to SHIFT with working reg=a and counter=shamt.
- SHIFT: each cycle, shift the working reg by 1 (sll fills 0; srl fills 0; sra fills the sign bit) and decrement the counter. When the counter reaches 0, go to DONE. Total latency = shamt+1 cycles from accept to out_valid.
- DONE: result and flags are held stable while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE next cycle and deassert out_valid. There is no same-cycle accept of a new op in DONE: back-to-back throughput is 1 op per 2 cycles minimum.
- Flags are computed from the final result. carry and overflow are 0 for all non-add/sub ops.
- Add/sub use WIDTH+1-bit arithmetic. overflow = (a_msb == b'_msb) & (res_msb != a_msb), where b' = ~b for sub.
- Inputs are ignored outside the accept cycle. Operand changes during SHIFT or DONE have no effect.
- flush=1 in any state: next state IDLE, out_valid=0, and any SHIFT progress is discarded. result and flags keep their last values.
- flush has priority over accept: flush & in_valid in IDLE accepts nothing.
- Asynchronous reset mid-SHIFT or mid-DONE forces the reset values immediately.

Test Plan:
- Reset then idle: assert reset during SHIFT with a=0xF, shamt=3 -> out_valid=0, in_ready=1, result=0 immediately.
- add a=0x7FFFFFFF, b=1 -> one cycle later out_valid=1, result=0x80000000, overflow=1, negative=1, carry=0; sub a=5, b=5 -> result=0, zero=1, carry=1.
- sra a=0x80000000, b=4 -> out_valid exactly 5 cycles after accept, result=0xF8000000; srl same operands -> 0x08000000; sll a=1, b=31 -> 0x80000000 after 32 cycles.
- slt a=0xFFFFFFFF, b=1 -> result=1; sltu same operands -> result=0; code 1111 -> result=0, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0 throughout; raise out_ready -> in_ready=1 the following cycle; a new op is accepted on that cycle.
- flush asserted on the 2nd SHIFT cycle of sll shamt=8 -> IDLE next cycle, out_valid never asserts. A following add 2+3 returns result=5 with latency 1.
